load_store_unit: RTL and testbench

Multi-cycle load/store initiator between the core's memory stage and the word-addressed `data_memory`. It accepts one byte, halfword or word access per handshake and converts it to word-only memory cycles: sub-word loads are extracted and extended, and sub-word stores use read-modify-write. It also generates a registered, glitch-free `WE` strobe, because `data_memory` writes on the rising edge of `WE`.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               access-size codes, FSM state encoding and byte/halfword lane
//               masks used when merging sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_t;

  // Lane masks in lane-0 position; shifted by the lane offset when merging
  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response handshake between the core memory stage
//               (master) and the load/store unit (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_funct3  : store flag and RV32I access size
//   req_addr, req_wdata : byte address and LSB-aligned store data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata, rsp_err  : extended load data, error flag
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic. Extracts and sign/zero-extends the
//               addressed byte or halfword of a memory word for loads, and
//               merges store data into the old word for sub-word stores.
//   addr_lo     in  2  : byte offset within the word
//   funct3      in  3  : RV32I access size
//   old_word    in  32 : word read from memory
//   store_data  in  32 : LSB-aligned store data
//   load_data   out 32 : extended load result
//   merged_word out 32 : word to write back for a store
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_shift = {addr_lo, 3'b000};
  // Halfword lane comes from addr[1] only; addr[0] is ignored here
  assign half_shift = {addr_lo[1], 4'b0000};
  assign lane_h     = addr_lo[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    lane_b = old_word[7:0];
    case (addr_lo)
      2'd0:    lane_b = old_word[7:0];
      2'd1:    lane_b = old_word[15:8];
      2'd2:    lane_b = old_word[23:16];
      default: lane_b = old_word[31:24];
    endcase
  end

  always_comb begin
    load_data   = '0;
    merged_word = old_word;
    case (funct3)
      F3_B: begin
        load_data   = {{24{lane_b[7]}}, lane_b};
        merged_word = (old_word & ~(LANE_MASK_B << byte_shift)) |
                      ((store_data & LANE_MASK_B) << byte_shift);
      end
      F3_H: begin
        load_data   = {{16{lane_h[15]}}, lane_h};
        merged_word = (old_word & ~(LANE_MASK_H << half_shift)) |
                      ((store_data & LANE_MASK_H) << half_shift);
      end
      F3_W: begin
        load_data   = old_word;
        merged_word = store_data;
      end
      F3_BU:   load_data = {24'd0, lane_b};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store initiator for a word-addressed data
//               memory that writes on the rising edge of WE. Sub-word loads
//               are extracted/extended; sub-word stores use read-modify-write.
//               WE is a registered, glitch-free one-cycle strobe with address
//               and data set up the cycle before and held the cycle after.
//   clk, rst  : clock, synchronous active-high reset
//   lsu       : request/response handshake (slave side)
//   mem_A     : word index (addr[31:2], zero-extended)
//   mem_WD    : write word
//   mem_WE    : write strobe, straight from a flop
//   mem_RD    : combinational read word
// Options     : define LSU_MISALIGN_TRAP_EN to report misaligned halfword and
//               word accesses as errors instead of ignoring alignment bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 65536
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  lsu,
  output logic [31:0]       mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
  localparam logic [2:0] ST_READ   = 3'(S_READ);
  localparam logic [2:0] ST_SETUP  = 3'(S_SETUP);
  localparam logic [2:0] ST_STROBE = 3'(S_STROBE);
  localparam logic [2:0] ST_RESP   = 3'(S_RESP);

  if (MEM_WORDS < 1) begin : g_mem_words_check
    $error("load_store_unit: MEM_WORDS must be at least 1");
  end

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign lsu.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = lsu.req_valid && lsu.req_ready;

  // Request legality, decoded from the live request at acceptance
  always_comb begin
    req_err = 1'b0;
    if (lsu.req_we) begin
      req_err = !((lsu.req_funct3 == F3_B) || (lsu.req_funct3 == F3_H) ||
                  (lsu.req_funct3 == F3_W));
    end else begin
      req_err = !((lsu.req_funct3 == F3_B)  || (lsu.req_funct3 == F3_H)  ||
                  (lsu.req_funct3 == F3_W)  || (lsu.req_funct3 == F3_BU) ||
                  (lsu.req_funct3 == F3_HU));
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (((lsu.req_funct3 == F3_H) || (lsu.req_funct3 == F3_HU)) && lsu.req_addr[0])
      req_err = 1'b1;
    if ((lsu.req_funct3 == F3_W) && (lsu.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .addr_lo     (addr_lo_q),
    .funct3      (funct3_q),
    .old_word    (mem_RD),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    mem_a_d     = mem_a_q;
    mem_wd_d    = mem_wd_q;
    // Response and strobe are single-cycle: cleared unless set below
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d      = lsu.req_we;
          funct3_d  = lsu.req_funct3;
          addr_lo_d = lsu.req_addr[1:0];
          wdata_d   = lsu.req_wdata;
          if (req_err) begin
            // Error path leaves the memory bus untouched
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            mem_a_d = {2'b00, lsu.req_addr[31:2]};
            if (lsu.req_we && (lsu.req_funct3 == F3_W)) begin
              mem_wd_d = lsu.req_wdata;
              state_d  = ST_SETUP;
            end else begin
              state_d  = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          mem_wd_d = merged_word;
          state_d  = ST_SETUP;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          state_d     = ST_RESP;
        end
      end
      ST_SETUP: begin
        // Address and data have been stable for a full cycle; raise WE
        mem_we_d = 1'b1;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // mem_A/mem_WD keep their values for hold time after the WE fall
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_A         = mem_a_q;
  assign mem_WD        = mem_wd_q;
  assign mem_WE        = mem_we_q;
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_rdata = rsp_rdata_q;
  assign lsu.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A vector table of
//               requests with expected responses feeds a response scoreboard
//               and a write scoreboard; a monitor checks WE shape, bus
//               stability and latency. Hand sequences cover reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  load_store_unit_if lif ();

  load_store_unit #(.MEM_WORDS(65536)) dut (
    .clk    (clk),
    .rst    (rst),
    .lsu    (lif),
    .mem_A  (mem_A),
    .mem_WD (mem_WD),
    .mem_WE (mem_WE),
    .mem_RD (mem_RD)
  );

  always #5 clk = ~clk;

  // 16-word memory model, aliased on mem_A[3:0]; writes on the WE rise
  logic [31:0] mem [0:15] = '{0: 32'h80FF_1234, 1: 32'h1122_3344, 3: 32'hCAFE_F00D,
                              5: 32'h8765_4321, default: 32'h0};
  logic [31:0] exp_mem [0:15] = '{0: 32'h80FF_1234, 1: 32'h1122_3344, 3: 32'hCAFE_F00D,
                                  5: 32'h8765_4321, default: 32'h0};
  assign mem_RD = mem[mem_A[3:0]];
  always @(posedge mem_WE) mem[mem_A[3:0]] <= mem_WD;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wr;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
  } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];
  vec_t     vecs[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int lat, input logic wr,
                              input logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.lat = lat; v.wr = wr; v.wd = wd;
    return v;
  endfunction

  // Drive one request; when scored, queue the expected response and write
  task automatic drive(input vec_t v, input bit scored);
    int       waited;
    rsp_exp_t r;
    wr_exp_t  w;
    waited = 0;
    @(negedge clk);
    while (!lif.req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!lif.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles, expected 1", waited);
      return;
    end
    lif.req_valid  = 1'b1;
    lif.req_we     = v.we;
    lif.req_funct3 = v.f3;
    lif.req_addr   = v.addr;
    lif.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    if (scored) begin
      r.rdata = v.rdata; r.err = v.err; r.lat = v.lat; r.acc = cyc;
      rsp_q.push_back(r);
      if (v.wr) begin
        w.a  = {2'b00, v.addr[31:2]};
        w.wd = v.wd;
        wr_q.push_back(w);
        exp_mem[v.addr[5:2]] = v.wd;
      end
    end
    // Scramble the bus so a design that fails to register the request shows it
    lif.req_valid  = 1'b0;
    lif.req_we     = 1'($urandom);
    lif.req_funct3 = 3'($urandom);
    lif.req_addr   = $urandom;
    lif.req_wdata  = $urandom;
  endtask

  // Monitor: response scoreboard, WE pulse shape, setup/hold stability
  logic        we_prev  = 1'b0;
  logic        rsp_prev = 1'b0;
  logic [31:0] a_prev   = '0;
  logic [31:0] wd_prev  = '0;

  always @(negedge clk) begin
    rsp_exp_t e;
    wr_exp_t  w;
    if (!rst) begin
      if (lif.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (cycle %0d)", cyc);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", lif.rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, lif.rsp_err}, {31'd0, e.err});
          check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      if (rsp_prev) check("ready_after_rsp", {31'd0, lif.req_ready}, 32'd1);
      if (mem_WE && we_prev) begin
        n_tests++;
        n_fail++;
        $display("FAIL we_width: mem_WE high 2 cycles running, expected 1-cycle pulse (cycle %0d)", cyc);
      end
      if (mem_WE && !we_prev) begin
        if (wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_we: mem_WE pulse with no write expected, mem_A=0x%08h", mem_A);
        end else begin
          w = wr_q.pop_front();
          check("we_addr", mem_A, w.a);
          check("we_data", mem_WD, w.wd);
        end
        check("a_setup_stable", mem_A, a_prev);
        check("wd_setup_stable", mem_WD, wd_prev);
      end
      if (!mem_WE && we_prev) begin
        check("a_hold_stable", mem_A, a_prev);
        check("wd_hold_stable", mem_WD, wd_prev);
      end
    end
    we_prev  = mem_WE && !rst;
    rsp_prev = lif.rsp_valid && !rst;
    a_prev   = mem_A;
    wd_prev  = mem_WD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lif.req_valid  = 1'b0;
    lif.req_we     = 1'b0;
    lif.req_funct3 = '0;
    lif.req_addr   = '0;
    lif.req_wdata  = '0;

    // ---- vector table ----
    vecs.push_back(mk(0, F3_B,  32'h1003, 32'h0,         32'hFFFF_FF80, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_BU, 32'h1003, 32'h0,         32'h0000_0080, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0002, 32'h0,         32'hFFFF_80FF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_HU, 32'h0000, 32'h0,         32'h0000_1234, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h0000, 32'h0,         32'h80FF_1234, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_B,  32'h0001, 32'h0,         32'h0000_0012, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0004, 32'h0,         32'h0000_3344, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, F3_B,  32'h0005, 32'hFFFF_FFAB, 32'h0,         0, 4, 1, 32'h1122_AB44));
    vecs.push_back(mk(1, F3_W,  32'h0008, 32'hDEAD_BEEF, 32'h0,         0, 3, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, F3_W,  32'h0008, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, F3_H,  32'h000E, 32'h1234_9876, 32'h0,         0, 4, 1, 32'h9876_F00D));
    vecs.push_back(mk(0, F3_HU, 32'h000E, 32'h0,         32'h0000_9876, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h000E, 32'h0,         32'hFFFF_9876, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, F3_B,  32'h0004, 32'h0000_007F, 32'h0,         0, 4, 1, 32'h1122_AB7F));
    vecs.push_back(mk(0, F3_W,  32'h0004, 32'h0,         32'h1122_AB7F, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'h0000, 32'h0,        32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3'b011, 32'h0000, 32'hFFFF_FFFF, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h0004, 32'hFFFF_FFFF, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 3'b110, 32'h0004, 32'h0,        32'h0,         1, 1, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_W,  32'h0002, 32'h0,         32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0001, 32'h0,         32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(0, F3_HU, 32'h0007, 32'h0,         32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(1, F3_W,  32'h0015, 32'h0000_0001, 32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(1, F3_H,  32'h0003, 32'h0000_ABCD, 32'h0,         1, 1, 0, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h0014, 32'h0,         32'h8765_4321, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h0000, 32'h0,         32'h80FF_1234, 0, 2, 0, 32'h0));
`else
    vecs.push_back(mk(0, F3_W,  32'h0002, 32'h0,         32'h80FF_1234, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0001, 32'h0,         32'h0000_1234, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_HU, 32'h0007, 32'h0,         32'h0000_1122, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, F3_W,  32'h0015, 32'h0000_0001, 32'h0,         0, 3, 1, 32'h0000_0001));
    vecs.push_back(mk(1, F3_H,  32'h0003, 32'h0000_ABCD, 32'h0,         0, 4, 1, 32'hABCD_1234));
    vecs.push_back(mk(0, F3_W,  32'h0014, 32'h0,         32'h0000_0001, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h0000, 32'h0,         32'hABCD_1234, 0, 2, 0, 32'h0));
`endif

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, lif.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, lif.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", lif.rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, lif.rsp_err},   32'd0);
    check("rst_mem_A",     mem_A,  32'd0);
    check("rst_mem_WD",    mem_WD, 32'd0);
    check("rst_mem_WE",    {31'd0, mem_WE}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, lif.req_ready}, 32'd1);

    // ---- table ----
    foreach (vecs[i]) drive(vecs[i], 1'b1);

    // ---- reset while an SH sits in SETUP ----
    for (int i = 0; i < 64 && rsp_q.size() != 0; i++) @(negedge clk);
    drive(mk(1, F3_H, 32'h0000, 32'h0000_FFFF, 32'h0, 0, 4, 0, 32'h0), 1'b0);
    @(posedge clk);          // READ -> SETUP
    #1 rst = 1'b1;           // held across the SETUP -> STROBE edge
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, lif.req_ready}, 32'd1);
    check("midrst_mem_WE",    {31'd0, mem_WE}, 32'd0);
    check("midrst_rsp_valid", {31'd0, lif.rsp_valid}, 32'd0);
    check("midrst_mem_A",     mem_A,  32'd0);
    check("midrst_mem_WD",    mem_WD, 32'd0);
    repeat (4) @(negedge clk);
    drive(mk(0, F3_W, 32'h0000, 32'h0, exp_mem[0], 0, 2, 0, 32'h0), 1'b1);

    // ---- drain and final image ----
    for (int i = 0; i < 64 && (rsp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("wr_queue_empty",  32'(wr_q.size()),  32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("mem_word%0d", i), mem[i], exp_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
